// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory request/response bus between the fetch
// stage (master) and instruction memory (slave).
interface fetch_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  imem_req_valid_o;
    logic                  imem_req_ready_i;
    logic [DATA_WIDTH-1:0] imem_req_addr_o;
    logic                  imem_rsp_valid_i;
    logic [DATA_WIDTH-1:0] imem_rsp_data_i;

    modport master (
        output imem_req_valid_o,
        output imem_req_addr_o,
        input  imem_req_ready_i,
        input  imem_rsp_valid_i,
        input  imem_rsp_data_i
    );

    modport slave (
        input  imem_req_valid_o,
        input  imem_req_addr_o,
        output imem_req_ready_i,
        output imem_rsp_valid_i,
        output imem_rsp_data_i
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: RISC-V instruction fetch stage. Holds the PC, issues word
// requests under a credit limit, queues returned words with their PCs in
// order, and flushes on redirects from execute (in-flight responses dropped).
// Optional feature: FETCH_MISALIGN_TRAP_EN -- misaligned redirect targets
// park the unit in a FAULT state instead of being silently word-aligned.
module fetch_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fetch_unit_if.master          imem,
    input  logic                  redirect_valid_i,
    input  logic [DATA_WIDTH-1:0] redirect_pc_i,
    output logic                  inst_valid_o,
    input  logic                  inst_ready_i,
    output logic [DATA_WIDTH-1:0] instruction_o,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic                  fault_o
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN
`ifdef FETCH_MISALIGN_TRAP_EN
        , ST_FAULT
`endif
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [CW-1:0]         out_cnt_q, out_cnt_d;
    logic [CW-1:0]         drop_cnt_q, drop_cnt_d;
    logic [CW-1:0]         fifo_cnt_q, fifo_cnt_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         tag_rd_q, tag_rd_d;
    logic [PW-1:0]         tag_wr_q, tag_wr_d;

    logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_pc   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] tag_mem   [FIFO_DEPTH];

    logic                  fifo_empty;
    logic                  credit_ok;
    logic                  req_fire;
    logic                  rsp;
    logic                  pop;
    logic                  push;
    logic                  dropping;
    logic [DATA_WIDTH-1:0] target;

    // Credits cover both queued words and requests still in flight.
    assign credit_ok  = ({1'b0, fifo_cnt_q} + {1'b0, out_cnt_q}) < (CW+1)'(FIFO_DEPTH);
    assign fifo_empty = (fifo_cnt_q == '0);

    assign imem.imem_req_valid_o = (state_q == ST_RUN) && !redirect_valid_i && credit_ok;
    assign imem.imem_req_addr_o  = pc_q;

    assign inst_valid_o  = !fifo_empty && !redirect_valid_i;
    assign instruction_o = fifo_empty ? NOP : fifo_data[rd_ptr_q];
    assign pc_o          = fifo_empty ? '0  : fifo_pc[rd_ptr_q];

    assign req_fire = imem.imem_req_valid_o && imem.imem_req_ready_i;
    assign rsp      = imem.imem_rsp_valid_i;
    assign pop      = inst_valid_o && inst_ready_i;
    assign dropping = (drop_cnt_q != '0);
    assign push     = rsp && !redirect_valid_i && !dropping;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign target  = redirect_pc_i;
    assign fault_o = (state_q == ST_FAULT);
`else
    // Low two target bits are ignored: fetch is always word aligned.
    assign target  = redirect_pc_i & ~DATA_WIDTH'(3);
    assign fault_o = 1'b0;
`endif

    // Next-state logic: normal fetch/queue bookkeeping, overridden by a redirect.
    always_comb begin
        // NOTE: every _d gets a default first, so no path through this block can infer a latch.
        state_d    = state_q;
        pc_d       = pc_q;
        out_cnt_d  = out_cnt_q + CW'(req_fire) - CW'(rsp);
        drop_cnt_d = drop_cnt_q;
        fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        tag_rd_d   = tag_rd_q;
        tag_wr_d   = tag_wr_q;

        if (state_q == ST_BOOT) begin
            state_d = ST_RUN;
        end
        if (req_fire) begin
            pc_d     = pc_q + DATA_WIDTH'(4);
            tag_wr_d = tag_wr_q + 1'b1;
        end
        // Every response retires one PC tag, whether it is kept or dropped.
        if (rsp) begin
            tag_rd_d = tag_rd_q + 1'b1;
            if (dropping) begin
                drop_cnt_d = drop_cnt_q - 1'b1;
            end
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        if (redirect_valid_i) begin
            pc_d       = target;
            fifo_cnt_d = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            // Everything still in flight after this cycle belongs to the old path.
            drop_cnt_d = out_cnt_q - CW'(rsp);
`ifdef FETCH_MISALIGN_TRAP_EN
            if (state_q != ST_BOOT) begin
                state_d = (target[1:0] != 2'b00) ? ST_FAULT : ST_RUN;
            end
`endif
        end
    end

    // Control state and counters, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC;
            out_cnt_q  <= '0;
            drop_cnt_q <= '0;
            fifo_cnt_q <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            tag_rd_q   <= '0;
            tag_wr_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q    <= state_d;
            pc_q       <= pc_d;
            out_cnt_q  <= out_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            fifo_cnt_q <= fifo_cnt_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            tag_rd_q   <= tag_rd_d;
            tag_wr_q   <= tag_wr_d;
        end
    end

    // Instruction queue and PC tag storage writes.
    // NOTE: storage arrays are not reset; the counters gate every read, so stale contents never reach an output.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr_q] <= imem.imem_rsp_data_i;
            fifo_pc[wr_ptr_q]   <= tag_mem[tag_rd_q];
        end
        if (req_fire) begin
            tag_mem[tag_wr_q] <= pc_q;
        end
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the RISC-V pipeline, directly upstream of decode. It holds the PC, issues word requests to instruction memory and buffers returned instruction words in a small in-order queue. It presents `instruction_o`/`pc_o` to decode, where `instruction_o` feeds the immediate generator and register decode. Branch and jump redirects from execute flush the queue and discard in-flight responses.

## Interface
- `RESET_PC`, default `32'h0000_0000`: first fetch address after reset.
- `FIFO_DEPTH`, default `2`: instruction queue entries; power of two, ≥2. This is also the maximum number of outstanding requests.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `imem_req_valid_o`  out  1  fetch request valid.
- `imem_req_ready_i`  in  1  memory accepts request.
- `imem_req_addr_o`  out  DATA_WIDTH  word address (byte address, bits [1:0]=0).
- `imem_rsp_valid_i`  in  1  response valid. Responses arrive in order, ≥1 cycle after the request handshake, and cannot be backpressured.
- `imem_rsp_data_i`  in  DATA_WIDTH  instruction word.
- `redirect_valid_i`  in  1  branch/jump taken, from execute.
- `redirect_pc_i`  in  DATA_WIDTH  redirect target.
- `inst_valid_o`  out  1  queue head valid to decode.
- `inst_ready_i`  in  1  decode accepts head.
- `instruction_o`  out  DATA_WIDTH  head instruction; `32'h0000_0013` (NOP) when the queue is empty.
- `pc_o`  out  DATA_WIDTH  PC of head instruction; 0 when the queue is empty.
- `fault_o`  out  1  misaligned-redirect fault (see Configuration).

## Operation
- States:
  - BOOT: held in reset, plus one cycle after reset release.
  - RUN.
  - FAULT: exists only with the macro defined.
  - Transitions: BOOT→RUN unconditionally. RUN→FAULT on a misaligned redirect. FAULT→RUN on an aligned redirect.
- Credit rule: `imem_req_valid_o = (state==RUN) && !redirect_valid_i && (fifo_count + outstanding_cnt < FIFO_DEPTH)`.
- Each request handshake: pc += 4, modulo 2^32, wraps at `32'hFFFF_FFFC`→0. `outstanding_cnt` increments.
- Each response: `outstanding_cnt` decrements.
  - If `drop_cnt > 0`: the word is discarded and `drop_cnt` decrements.
  - Otherwise the word is written to the queue with its PC, taken from an internal in-order PC tag queue.
- Queue write and read in the same cycle are both allowed, including when the queue is full. A full queue never receives a write, because credits prevent it.
- `inst_valid_o = !fifo_empty && !redirect_valid_i`. The head pops on `inst_valid_o && inst_ready_i`.
- Redirect (highest priority):
  - In that cycle: no request is issued and no pop occurs. The response arriving in that cycle is discarded.
  - Next cycle: pc = target, queue empty, `drop_cnt = outstanding_cnt − imem_rsp_valid_i`. `outstanding_cnt` keeps tracking those requests.
  - A redirect while `drop_cnt > 0` recomputes `drop_cnt` by the same rule.
- Counters are `$clog2(FIFO_DEPTH)+1` bits wide and never overflow or underflow under legal stimulus.

## Timing
- Reset values:
  - `imem_req_valid_o` 0; `imem_req_addr_o` = `RESET_PC`.
  - `inst_valid_o` 0; `instruction_o` NOP; `pc_o` 0; `fault_o` 0.
  - All counters 0; state BOOT.
- The first request is asserted 1 cycle after `rst_n` deasserts.
- The queue write is registered: a response in cycle N makes `inst_valid_o` visible in N+1 at the earliest. There is no bypass.
- Redirect in cycle N → request to the target in N+1 → response ≥N+2 → `inst_valid_o` ≥N+3.
- Asynchronous reset mid-operation immediately clears all state and outputs. Responses to pre-reset requests are the memory's responsibility; memory is reset together with this block.

## Configuration
- `FETCH_MISALIGN_TRAP_EN` defined:
  - A redirect with `redirect_pc_i[1:0] != 0` enters FAULT and sets `fault_o` 1 from the next cycle.
  - In FAULT: no requests; the queue is flushed and drop handling runs as for any redirect.
  - `fault_o` clears on the next aligned redirect (→RUN) or on reset.
- Not defined:
  - `redirect_pc_i[1:0]` is ignored and forced to 0.
  - No FAULT state; `fault_o` tied 0.

## Test plan
- Reset release, `imem_req_ready_i`=1, 1-cycle memory, `inst_ready_i`=1 → requests to 0x0, 0x4, 0x8…; `instruction_o` = returned words with matching `pc_o`; sustained 1 instruction/cycle after fill.
- `inst_ready_i`=0 for 10 cycles → exactly `FIFO_DEPTH` (2) requests issued, then `imem_req_valid_o`=0; no words lost after release.
- Redirect to 0x100 with 2 outstanding requests (response latency 3) → both responses discarded; next `pc_o`=0x100 with the word from 0x100; `inst_valid_o` low during the redirect cycle.
- Redirect in the same cycle as a response, plus a second redirect 1 cycle later → only target-2 instructions reach decode.
- PC wrap: redirect to 0xFFFF_FFFC → request addresses 0xFFFF_FFFC then 0x0.
- With `FETCH_MISALIGN_TRAP_EN`: redirect to 0x102 → `fault_o`=1, no requests; then redirect to 0x200 → `fault_o`=0, fetching resumes at 0x200. Without the macro, redirect to 0x102 fetches from 0x100.
